// File: rtl/gshare_predictor.sv
// gshare_predictor: global-history branch direction predictor.
//
// A table of 2^IDX_W saturating counters is indexed by the branch PC, optionally
// XORed with a global history register (GHR). Predictions are registered and
// appear one cycle after a request; resolved branches train the table. After
// every reset the table is cleared by a hardware sweep before requests are served.
//
// Build option: define PRED_GHIST_EN to enable gshare hashing with the GHR.
// Without it the GHR is absent and the table is indexed bimodally by PC only.
//
// Ports:
//   clk_i         clock, all state updates on the rising edge
//   rst_i         synchronous active-high reset
//   req_i/idx_i   prediction request and its branch PC
//   prediction_o  registered predicted direction (1 = taken)
//   pred_valid_o  one-cycle pulse per accepted request
//   update_en_i   resolved-branch update strobe
//   upd_idx_i     PC of the resolved branch
//   br_result_i   actual outcome (1 = taken)
//   correct_i     earlier prediction was correct (used only with update_en_i)
//   ready_o       init sweep done
//   miss_count_o  saturating mispredict count
module gshare_predictor #(
    parameter int unsigned IDX_W    = 10,
    parameter int unsigned HIST_LEN = 8,
    parameter int unsigned CTR_W    = 2,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_i,
    input  logic [31:0]      idx_i,
    output logic             prediction_o,
    output logic             pred_valid_o,
    input  logic             update_en_i,
    input  logic [31:0]      upd_idx_i,
    input  logic             br_result_i,
    input  logic             correct_i,
    output logic             ready_o,
    output logic [CNT_W-1:0] miss_count_o
);

    localparam int unsigned      DEPTH    = 1 << IDX_W;
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((1 << (CTR_W - 1)) - 1);
    localparam logic [CTR_W-1:0] CTR_MAX  = '1;
    localparam logic [CNT_W-1:0] MISS_MAX = '1;
    localparam logic [IDX_W-1:0] LAST_ROW = '1;

    typedef enum logic {StInit, StRun} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] sweep_ptr_q, sweep_ptr_d;
    logic [CTR_W-1:0] table_q [DEPTH];

    logic [IDX_W-1:0] req_row;
    logic [IDX_W-1:0] upd_row;
    logic [CTR_W-1:0] upd_ctr;
    logic [CTR_W-1:0] ctr_next;
    logic             run;

    assign run     = (state_q == StRun);
    assign ready_o = run;

    // Only PC bits [IDX_W+1:2] participate in the index.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{idx_i[31:IDX_W+2], idx_i[1:0],
                              upd_idx_i[31:IDX_W+2], upd_idx_i[1:0]};

`ifdef PRED_GHIST_EN
    logic [HIST_LEN-1:0] ghr_q, ghr_d;

    // Both ports hash with the GHR as it stands before this edge's update.
    assign req_row = idx_i[IDX_W+1:2] ^ IDX_W'(ghr_q);
    assign upd_row = upd_idx_i[IDX_W+1:2] ^ IDX_W'(ghr_q);

    always_comb begin
        ghr_d = ghr_q;
        if (run && update_en_i) begin
            // Shift in the outcome; truncation drops the oldest bit.
            ghr_d = HIST_LEN'({ghr_q, br_result_i});
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end
`else
    assign req_row = idx_i[IDX_W+1:2];
    assign upd_row = upd_idx_i[IDX_W+1:2];

    logic unused_hist_len;
    assign unused_hist_len = (HIST_LEN == 0);
`endif

    // Saturating counter step for the update port.
    always_comb begin
        upd_ctr  = table_q[upd_row];
        ctr_next = upd_ctr;
        if (br_result_i) begin
            if (upd_ctr != CTR_MAX) begin
                ctr_next = upd_ctr + CTR_W'(1);
            end
        end else if (upd_ctr != '0) begin
            ctr_next = upd_ctr - CTR_W'(1);
        end
    end

    always_comb begin
        state_d     = state_q;
        sweep_ptr_d = sweep_ptr_q;
        case (state_q)
            StInit: begin
                sweep_ptr_d = sweep_ptr_q + IDX_W'(1);
                if (sweep_ptr_q == LAST_ROW) begin
                    state_d = StRun;
                end
            end
            StRun:   state_d = StRun;
            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StInit;
            sweep_ptr_q <= '0;
        end else begin
            state_q     <= state_d;
            sweep_ptr_q <= sweep_ptr_d;
        end
    end

    // Table has no reset; the init sweep provides its known state.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (state_q == StInit) begin
                table_q[sweep_ptr_q] <= CTR_INIT;
            end else if (update_en_i) begin
                table_q[upd_row] <= ctr_next;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prediction_o <= 1'b0;
            pred_valid_o <= 1'b0;
            miss_count_o <= '0;
        end else begin
            pred_valid_o <= run && req_i;
            if (run && req_i) begin
                prediction_o <= table_q[req_row][CTR_W-1];
            end
            if (run && update_en_i && !correct_i && (miss_count_o != MISS_MAX)) begin
                miss_count_o <= miss_count_o + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/gshare_predictor.md
# gshare_predictor

Parametrised global-history branch direction predictor; successor to the fixed-size predictor core instantiated under the top-level wrapper. It keeps a table of 2^IDX_W saturating counters indexed by PC hashed with a global history register (GHR). It returns registered predictions one cycle after request and trains on resolved branches. After every reset it clears the table with a hardware init sweep and counts mispredictions for performance monitoring.

## Interface
- IDX_W, 10: table index width; table depth = 2^IDX_W; legal 4..14
- HIST_LEN, 8: GHR length in bits; legal 1..IDX_W
- CTR_W, 2: counter width; legal 2..4
- CNT_W, 16: miss counter width
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  synchronous, active-high reset
- req_i  in  1  prediction request, sampled with idx_i
- idx_i  in  32  branch PC for the request
- prediction_o  out  1  predicted direction, 1 = taken
- pred_valid_o  out  1  prediction_o valid this cycle
- update_en_i  in  1  resolved-branch update strobe
- upd_idx_i  in  32  PC of the resolved branch
- br_result_i  in  1  actual outcome, 1 = taken
- correct_i  in  1  1 = earlier prediction for this branch was correct
- ready_o  out  1  init sweep done; requests and updates accepted
- miss_count_o  out  CNT_W  saturating mispredict count

## Operation
- Row hash: row(pc) = pc[IDX_W+1:2] XOR {zero-extend GHR[HIST_LEN-1:0]} (GHR in low bits).
- Counter init value: 2^(CTR_W-1)-1 (weakly not-taken). Prediction = counter MSB.
- FSM states INIT, RUN.
  - INIT: write init value to row sweep_ptr, sweep_ptr +1 per cycle from 0. Leave at sweep_ptr = 2^IDX_W-1 written; next cycle RUN. req_i and update_en_i ignored, no state change besides table/sweep_ptr.
  - RUN: ready_o = 1; serve requests and updates. Only rst_i leaves RUN.
- Request (RUN, req_i=1): read counter at row(idx_i) with current GHR; register MSB into prediction_o, set pred_valid_o.
- Update (RUN, update_en_i=1): counter at row(upd_idx_i), hashed with the GHR value *before* this update, +1 if br_result_i=1 else -1; saturate at 0 and 2^CTR_W-1. Same edge: GHR <= {GHR[HIST_LEN-2:0], br_result_i}.
- correct_i=0 with update_en_i=1 in RUN: miss_count_o +1, saturating at 2^CNT_W-1. correct_i is ignored without update_en_i.
- GHR is non-speculative; only updates shift it.

## Timing
- Reset values: prediction_o 0, pred_valid_o 0, ready_o 0, miss_count_o 0, GHR 0, sweep_ptr 0, state INIT.
- Init takes 2^IDX_W cycles after the rst_i-low edge. ready_o rises on the following cycle, e.g. IDX_W=4: rst_i low at edge 0, ready_o=1 after edge 16.
- Prediction latency 1: req_i at cycle t gives prediction_o/pred_valid_o at t+1. pred_valid_o is a one-cycle pulse per request; back-to-back requests give back-to-back valids. pred_valid_o=0 while ready_o=0.
- Request and update on the same row in the same cycle: the request reads the old counter and the old GHR. A request in the next cycle sees both updates.
- Counter at max with taken update: stays at max. Counter at 0 with not-taken update: stays at 0. The miss count holds at all-ones.
- rst_i asserted mid-sweep or in RUN: the next edge forces the reset values, and the sweep restarts from row 0. A pending pred_valid_o is dropped.

## Configuration
- PRED_GHIST_EN defined: gshare hashing as above; GHR present.
- Not defined: GHR removed (no flops), row(pc) = pc[IDX_W+1:2] (bimodal). Updates still train counters. HIST_LEN is ignored.

## Test plan
- Reset/init, IDX_W=4: pulse rst_i, then req_i held high → ready_o=0 and pred_valid_o=0 for 16 cycles, ready_o=1 at cycle 17. First prediction for any PC is 0.
- Training, CTR_W=2, macro off: 2 taken updates to PC 0x40, then req PC 0x40 → prediction_o=1 one cycle later. 4 more taken updates then 1 not-taken → still 1 (saturation at 3 then 2).
- Same-cycle hazard: counter=1, req and taken update to the same row in one cycle → prediction 0. Repeat the req next cycle → 1.
- History, macro on, HIST_LEN=2: updates taken, taken on PC 0x100 → GHR=2'b11. Req PC 0x100 indexes row 0x40^0x3=0x43 → prediction 0 (untrained row).
- Miss counter, CNT_W=2: 5 updates with correct_i=0 → miss_count_o=3. correct_i=0 with update_en_i=0 → no change.
- Reset mid-operation: rst_i in RUN after training → miss_count_o=0, GHR=0, ready_o=0 for 2^IDX_W cycles, trained PC predicts 0 afterwards.
